// File: rtl/regfile_mp.sv
// Multi-port register file: async read ports, two byte-enabled write ports
// (port 1 younger, higher priority), optional write->read bypass and a busy
// scoreboard for the hazard unit.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic [DATA_W/8-1:0]        wr0_be,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic [DATA_W/8-1:0]        wr1_be,
    input  logic                       claim_en,
    input  logic [ADDR_W-1:0]          claim_addr,
    output logic [(1<<ADDR_W)-1:0]     busy_vec
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    logic              wr0_ok;
    logic              wr1_ok;
    logic              claim_ok;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] word;
    logic              hit0;
    logic              hit1;
    logic              clr;
    logic              bsy;

    // Writes/claims to register 0 are dropped when it is hardwired to zero
    assign wr0_ok   = wr0_en   && !(ZERO_REG && (wr0_addr   == '0));
    assign wr1_ok   = wr1_en   && !(ZERO_REG && (wr1_addr   == '0));
    assign claim_ok = claim_en && !(ZERO_REG && (claim_addr == '0));

    assign busy_vec = busy;

    // Register storage: per-byte write, port 1 applied last so it wins overlaps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wr0_ok && wr0_be[b]) begin
                    regs[wr0_addr][b*8 +: 8] <= wr0_data[b*8 +: 8];
                end
            end
            for (int unsigned b = 0; b < NB; b++) begin
                if (wr1_ok && wr1_be[b]) begin
                    regs[wr1_addr][b*8 +: 8] <= wr1_data[b*8 +: 8];
                end
            end
        end
    end

    // Scoreboard next state: writebacks clear, then a claim re-sets (claim wins)
    always_comb begin
        busy_nxt = busy;
        if (wr0_ok && (|wr0_be)) begin
            busy_nxt[wr0_addr] = 1'b0;
        end
        if (wr1_ok && (|wr1_be)) begin
            busy_nxt[wr1_addr] = 1'b0;
        end
        if (claim_ok) begin
            busy_nxt[claim_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_nxt[0] = 1'b0;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read ports: stored value merged with same-cycle writes when bypass is on
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        word    = '0;
        hit0    = 1'b0;
        hit1    = 1'b0;
        clr     = 1'b0;
        bsy     = 1'b0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra   = rd_addr[k*ADDR_W +: ADDR_W];
            word = regs[ra];
            hit0 = BYPASS && wr0_ok && (wr0_addr == ra);
            hit1 = BYPASS && wr1_ok && (wr1_addr == ra);
            for (int unsigned b = 0; b < NB; b++) begin
                if (hit0 && wr0_be[b]) begin
                    word[b*8 +: 8] = wr0_data[b*8 +: 8];
                end
                if (hit1 && wr1_be[b]) begin
                    word[b*8 +: 8] = wr1_data[b*8 +: 8];
                end
            end
            clr = (hit0 && (|wr0_be)) || (hit1 && (|wr1_be));
            bsy = busy[ra] && !clr;
            if ((ZERO_REG && (ra == '0)) || !reset) begin
                word = '0;
                bsy  = 1'b0;
            end
            rd_data[k*DATA_W +: DATA_W] = word;
            rd_busy[k]                  = bsy;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters (bypass and zero register on).
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en;
    logic [4:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic [3:0]  wr0_be;
    logic        wr1_en;
    logic [4:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic [3:0]  wr1_be;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic [31:0] busy_vec;

    int n_cmp;
    int n_bad;

    regfile_mp dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr0_en     (wr0_en),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr0_be     (wr0_be),
        .wr1_en     (wr1_en),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .wr1_be     (wr1_be),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy_vec   (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0; wr0_be = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0; wr1_be = '0;
        claim_en = 1'b0; claim_addr = '0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        rd(5'd0, 5'd0);
        reset = 1'b0;

        // 1: reset state
        #12;
        chk("rst_busy_vec", 64'(busy_vec), 64'h0);
        chk("rst_rd_data", rd_data, 64'h0);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            #1;
            chk($sformatf("init_rd0_a%0d", i), 64'(rd_data[31:0]), 64'h0);
            chk($sformatf("init_rd1_a%0d", 31 - i), 64'(rd_data[63:32]), 64'h0);
        end
        chk("init_busy_vec", 64'(busy_vec), 64'h0);

        // 2: full write with same-cycle bypass
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF; wr0_be = 4'hF;
        rd(5'd5, 5'd6);
        #1;
        chk("byp_rd5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("byp_rd6", 64'(rd_data[63:32]), 64'h0);
        @(negedge clk);
        idle();
        #1;
        chk("stored_rd5", 64'(rd_data[31:0]), 64'hDEADBEEF);

        // 3: byte-enable merge with port 1 priority
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h11223344; wr1_be = 4'hF;
        @(negedge clk);
        idle();
        rd(5'd7, 5'd5);
        #1;
        chk("pre_rd7", 64'(rd_data[31:0]), 64'h11223344);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hAAAAAAAA; wr0_be = 4'h3;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hBBBBBBBB; wr1_be = 4'h6;
        #1;
        chk("merge_byp_rd7", 64'(rd_data[31:0]), 64'h11BBBBAA);
        @(negedge clk);
        idle();
        #1;
        chk("merge_stored_rd7", 64'(rd_data[31:0]), 64'h11BBBBAA);
        chk("merge_rd5_kept", 64'(rd_data[63:32]), 64'hDEADBEEF);

        // 4: scoreboard claim / clear / claim-wins / be=0 no clear
        claim_en = 1'b1; claim_addr = 5'd9;
        rd(5'd7, 5'd9);
        #1;
        chk("claim_not_visible", 64'(rd_busy), 64'h0);
        @(negedge clk);
        idle();
        #1;
        chk("claim_busy_vec", 64'(busy_vec), 64'h0000_0200);
        chk("claim_rd_busy", 64'(rd_busy), 64'h2);
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h0000_0099; wr1_be = 4'hF;
        claim_en = 1'b1; claim_addr = 5'd9;
        #1;
        chk("clr_byp_rd_busy", 64'(rd_busy), 64'h0);
        @(negedge clk);
        idle();
        #1;
        chk("claim_wins_busy", 64'(busy_vec), 64'h0000_0200);
        chk("claim_wins_rd_busy", 64'(rd_busy), 64'h2);
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hFFFF_FFFF; wr0_be = 4'h0;
        #1;
        chk("be0_rd_busy", 64'(rd_busy), 64'h2);
        chk("be0_rd9_data", 64'(rd_data[63:32]), 64'h0000_0099);
        @(negedge clk);
        idle();
        #1;
        chk("be0_no_clear", 64'(busy_vec), 64'h0000_0200);
        chk("be0_stored_rd9", 64'(rd_data[63:32]), 64'h0000_0099);
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h0000_1234; wr0_be = 4'h1;
        @(negedge clk);
        idle();
        #1;
        chk("clear_busy_vec", 64'(busy_vec), 64'h0);
        chk("clear_rd9_data", 64'(rd_data[63:32]), 64'h0000_0034);

        // 5: register zero ignores writes and claims
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h0000_1234; wr0_be = 4'hF;
        claim_en = 1'b1; claim_addr = 5'd0;
        rd(5'd0, 5'd5);
        #1;
        chk("zero_byp_rd0", 64'(rd_data[31:0]), 64'h0);
        @(negedge clk);
        idle();
        #1;
        chk("zero_rd0", 64'(rd_data[31:0]), 64'h0);
        chk("zero_busy_vec", 64'(busy_vec), 64'h0);
        chk("zero_rd_busy", 64'(rd_busy), 64'h0);

        // 6: async reset between edges aborts pending writes
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'hCAFEF00D; wr0_be = 4'hF;
        claim_en = 1'b1; claim_addr = 5'd3;
        @(negedge clk);
        idle();
        rd(5'd12, 5'd5);
        #1;
        chk("pre_rst_rd12", 64'(rd_data[31:0]), 64'hCAFEF00D);
        chk("pre_rst_busy", 64'(busy_vec), 64'h0000_0008);
        wr0_en = 1'b1; wr0_addr = 5'd13; wr0_data = 32'h5555_5555; wr0_be = 4'hF;
        claim_en = 1'b1; claim_addr = 5'd14;
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy_vec), 64'h0);
        chk("rst_mid_rd", rd_data, 64'h0);
        idle();
        #1;
        reset = 1'b1;
        #1;
        chk("rst_after_rd12_rd5", rd_data, 64'h0);
        rd(5'd13, 5'd14);
        #1;
        chk("rst_after_rd13", 64'(rd_data[31:0]), 64'h0);
        @(negedge clk);
        #1;
        chk("rst_post_edge_busy", 64'(busy_vec), 64'h0);
        chk("rst_post_edge_rd13", 64'(rd_data[31:0]), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
